// File: rtl/if_fetch_unit.sv
// IF stage of the pipelined MIPS core: owns the PC and instruction memory, feeds IF/ID,
// and handles debug program load, start, single-step and halt.
module if_fetch_unit #(
    parameter int                     NB_INSTRUCT = 32,
    parameter int                     NB_PC       = 9,
    parameter logic [NB_INSTRUCT-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_load_en,
    input  logic [NB_PC-3:0]       i_load_addr,
    input  logic [NB_INSTRUCT-1:0] i_load_data,
    input  logic                   i_start,
    input  logic                   i_step_mode,
    input  logic                   i_step,
    input  logic                   i_PC_write,
    input  logic                   i_branch_taken,
    input  logic [NB_PC-1:0]       i_branch_target,
    input  logic                   i_jump,
    input  logic [NB_PC-1:0]       i_jump_target,
    output logic [NB_INSTRUCT-1:0] o_instruction,
    output logic [NB_PC-1:0]       o_PC,
    output logic                   o_valid,
    output logic                   o_halted
);
    localparam int NB_ADDR = NB_PC - 2;
    localparam int DEPTH   = 2 ** NB_ADDR;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

    typedef struct packed {
        logic [NB_PC-1:0]       pc;
        logic [NB_INSTRUCT-1:0] instr;
    } fetch_t;

    state_t                 state, state_nxt;
    fetch_t                 fetch, fetch_nxt;
    logic [NB_INSTRUCT-1:0] mem [DEPTH];
    logic [NB_PC-1:0]       pc_seq, pc_target, pc_next;
    logic [NB_ADDR-1:0]     rd_addr;
    logic [NB_INSTRUCT-1:0] rd_data;
    logic                   is_halt_word, advance, mem_we;

    // pc+4 wraps naturally at NB_PC bits
    assign pc_seq       = fetch.pc + NB_PC'(4);
    assign pc_target    = i_branch_taken ? i_branch_target :
                          i_jump         ? i_jump_target   : pc_seq;
    assign pc_next      = pc_target & ~NB_PC'(3);
    assign is_halt_word = (fetch.instr == HALT_WORD);
    assign advance      = (state == ST_RUN) & i_PC_write & (~i_step_mode | i_step) & ~is_halt_word;
    assign mem_we       = (state == ST_IDLE) & i_load_en;

    // Start always fetches word 0; otherwise read at the redirect/sequential target
    assign rd_addr = (state == ST_IDLE) ? '0 : pc_next[NB_PC-1:2];
    assign rd_data = mem[rd_addr];

    always_ff @(posedge i_clk) begin
        if (mem_we)
            mem[i_load_addr] <= i_load_data;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
            fetch <= '0;
        end else begin
            state <= state_nxt;
            fetch <= fetch_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fetch_nxt = fetch;
        case (state)
            ST_IDLE: begin
                if (i_start && !i_load_en) begin
                    state_nxt       = ST_RUN;
                    fetch_nxt.pc    = '0;
                    fetch_nxt.instr = rd_data;
                end
            end
            ST_RUN: begin
                // PC is frozen once the halt word is on the output
                if (is_halt_word) begin
                    state_nxt = ST_HALT;
                end else if (advance) begin
                    fetch_nxt.pc    = pc_next;
                    fetch_nxt.instr = rd_data;
                end
            end
            ST_HALT: ;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_instruction = fetch.instr;
    assign o_PC          = (state == ST_IDLE) ? '0 : pc_seq;
    assign o_valid       = (state != ST_IDLE);
    assign o_halted      = (state == ST_HALT);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: program table, directed corner sequences, and randomized run vs. a reference model.
module tb_if_fetch_unit;
    localparam int          NB_PC = 9;
    localparam int          DEPTH = 128;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_reset, i_load_en, i_start, i_step_mode, i_step, i_PC_write;
    logic        i_branch_taken, i_jump;
    logic [6:0]  i_load_addr;
    logic [31:0] i_load_data;
    logic [8:0]  i_branch_target, i_jump_target;
    logic [31:0] o_instruction;
    logic [8:0]  o_PC;
    logic        o_valid, o_halted;

    if_fetch_unit #(.NB_INSTRUCT(32), .NB_PC(NB_PC), .HALT_WORD(HALT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_load_en(i_load_en), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
        .i_start(i_start), .i_step_mode(i_step_mode), .i_step(i_step), .i_PC_write(i_PC_write),
        .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
        .i_jump(i_jump), .i_jump_target(i_jump_target),
        .o_instruction(o_instruction), .o_PC(o_PC), .o_valid(o_valid), .o_halted(o_halted)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: 0 = idle, 1 = run, 2 = halt; pc is a plain byte address
    logic [31:0] m_mem [DEPTH];
    int          m_state = 0;
    int          m_pc = 0;
    logic [31:0] m_instr = '0;

    typedef struct {
        logic        load_en;
        logic [6:0]  addr;
        logic [31:0] data;
        logic        start;
        logic [31:0] e_instr;
        logic [8:0]  e_pc;
        logic        e_valid;
        logic        e_halted;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " instr"},  o_instruction, m_instr);
        chk({tag, " pc"},     32'(o_PC), (m_state == 0) ? 0 : (m_pc + 4) % 512);
        chk({tag, " valid"},  32'(o_valid), 32'(m_state != 0));
        chk({tag, " halted"}, 32'(o_halted), 32'(m_state == 2));
    endtask

    task automatic model_edge();
        int nxt;
        case (m_state)
            0: begin
                if (i_load_en) m_mem[i_load_addr] = i_load_data;
                else if (i_start) begin m_state = 1; m_pc = 0; m_instr = m_mem[0]; end
            end
            1: begin
                if (m_instr == HALT) m_state = 2;
                else if (i_PC_write && (!i_step_mode || i_step)) begin
                    if (i_branch_taken)  nxt = int'(i_branch_target);
                    else if (i_jump)     nxt = int'(i_jump_target);
                    else                 nxt = (m_pc + 4) % 512;
                    m_pc    = nxt - (nxt % 4);
                    m_instr = m_mem[m_pc / 4];
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick(input string tag);
        @(posedge i_clk);
        model_edge();
        #1;
        chk_model(tag);
    endtask

    task automatic quiet();
        i_load_en = 0; i_load_addr = '0; i_load_data = '0; i_start = 0;
        i_step_mode = 0; i_step = 0; i_PC_write = 1;
        i_branch_taken = 0; i_branch_target = '0; i_jump = 0; i_jump_target = '0;
    endtask

    // Asserts reset mid-cycle, checks outputs clear at once, releases after the next edge
    task automatic do_reset(input string tag);
        #3 i_reset = 0;
        #1;
        m_state = 0; m_pc = 0; m_instr = '0;
        chk_model({tag, " async"});
        @(posedge i_clk);
        #1;
        chk_model({tag, " held"});
        i_reset = 1;
    endtask

    task automatic load_word(input int addr, input logic [31:0] data);
        i_load_en = 1; i_load_addr = 7'(addr); i_load_data = data;
        tick("load");
        i_load_en = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1;
        quiet();
        do_reset("reset");

        tbl[0]  = '{1, 0, 32'h2001_0005, 0, 32'h0,         9'd0,  0, 0};
        tbl[1]  = '{1, 1, 32'h2002_0003, 0, 32'h0,         9'd0,  0, 0};
        tbl[2]  = '{1, 2, 32'h0022_1820, 0, 32'h0,         9'd0,  0, 0};
        tbl[3]  = '{1, 3, HALT,          0, 32'h0,         9'd0,  0, 0};
        tbl[4]  = '{0, 0, 32'h0,         1, 32'h2001_0005, 9'd4,  1, 0};
        tbl[5]  = '{0, 0, 32'h0,         0, 32'h2002_0003, 9'd8,  1, 0};
        tbl[6]  = '{0, 0, 32'h0,         0, 32'h0022_1820, 9'd12, 1, 0};
        tbl[7]  = '{0, 0, 32'h0,         0, HALT,          9'd16, 1, 0};
        tbl[8]  = '{0, 0, 32'h0,         0, HALT,          9'd16, 1, 1};
        tbl[9]  = '{1, 0, 32'h0,         1, HALT,          9'd16, 1, 1};
        tbl[10] = '{0, 0, 32'h0,         1, HALT,          9'd16, 1, 1};
        tbl[11] = '{0, 0, 32'h0,         0, HALT,          9'd16, 1, 1};
        for (int i = 0; i < 12; i++) begin
            i_load_en = tbl[i].load_en; i_load_addr = tbl[i].addr;
            i_load_data = tbl[i].data;  i_start = tbl[i].start;
            tick("tbl");
            chk($sformatf("tbl%0d instr", i), o_instruction, tbl[i].e_instr);
            chk($sformatf("tbl%0d pc", i), 32'(o_PC), 32'(tbl[i].e_pc));
            chk($sformatf("tbl%0d valid", i), 32'(o_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d halted", i), 32'(o_halted), 32'(tbl[i].e_halted));
        end
        quiet();

        // Fill the rest of memory with non-halt words; mem[0..2] stay from the table
        do_reset("rst1");
        for (int i = 3; i < DEPTH; i++) load_word(i, 32'h0100_0000 + 32'(i));
        i_start = 1; tick("start"); i_start = 0;
        chk("start intact", o_instruction, 32'h2001_0005);

        tick("run"); tick("run");
        chk("pre-stall pc", 32'(o_PC), 32'd12);
        i_PC_write = 0;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            chk("stall instr", o_instruction, 32'h0022_1820);
            chk("stall pc", 32'(o_PC), 32'd12);
        end
        i_PC_write = 1;
        tick("resume");
        chk("resume instr", o_instruction, 32'h0100_0003);

        i_jump = 1; i_jump_target = 9'h004; tick("jmp4"); i_jump = 0;
        chk("at pc4", 32'(o_PC), 32'd8);
        i_branch_taken = 1; i_branch_target = 9'h040; i_jump = 1; i_jump_target = 9'h080;
        tick("prio");
        chk("prio pc", 32'(o_PC), 32'h44);
        chk("prio instr", o_instruction, 32'h0100_0010);
        quiet();

        i_step_mode = 1;
        tick("step idle"); tick("step idle");
        chk("step hold", 32'(o_PC), 32'h44);
        i_step = 1; tick("step1"); i_step = 0;
        chk("step1 pc", 32'(o_PC), 32'h48);
        tick("step gap");
        chk("step gap pc", 32'(o_PC), 32'h48);
        i_step = 1; tick("step2"); i_step = 0;
        chk("step2 pc", 32'(o_PC), 32'h4C);
        i_PC_write = 0; i_step = 1; tick("step lost"); i_step = 0; i_PC_write = 1;
        tick("step lost2");
        chk("step lost pc", 32'(o_PC), 32'h4C);
        i_step_mode = 0;

        i_jump = 1; i_jump_target = 9'h1FC; tick("wrap jmp"); i_jump = 0;
        chk("wrap pc", 32'(o_PC), 32'h000);
        chk("wrap instr", o_instruction, 32'h0100_007F);
        tick("wrap seq");
        chk("wrap seq pc", 32'(o_PC), 32'h004);
        chk("wrap seq instr", o_instruction, 32'h2001_0005);

        i_jump = 1; i_jump_target = 9'h020; tick("jmp20"); i_jump = 0;
        chk("pc20", 32'(o_PC), 32'h24);
        do_reset("rst mid");
        load_word(5, 32'hDEAD_0005);
        i_start = 1; tick("restart"); i_start = 0;
        chk("restart instr", o_instruction, 32'h2001_0005);
        for (int i = 0; i < 5; i++) tick("rerun");
        chk("rerun pc", 32'(o_PC), 32'h18);
        chk("rerun instr", o_instruction, 32'hDEAD_0005);

        for (int run = 0; run < 4; run++) begin
            quiet();
            do_reset("rst rnd");
            for (int i = 0; i < DEPTH; i++) begin
                logic [31:0] w;
                w = $urandom;
                if (w == HALT) w = 32'h0;
                if (i >= 64 && $urandom_range(0, 40) == 0) w = HALT;
                load_word(i, w);
            end
            i_start = 1; tick("rnd start"); i_start = 0;
            for (int c = 0; c < 250; c++) begin
                i_PC_write      = ($urandom_range(0, 3) != 0);
                i_step_mode     = (run % 2 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                i_step          = 1'($urandom_range(0, 1));
                i_branch_taken  = ($urandom_range(0, 7) == 0);
                i_branch_target = 9'($urandom_range(0, 127) * 4);
                i_jump          = ($urandom_range(0, 7) == 0);
                i_jump_target   = 9'($urandom_range(0, 127) * 4);
                i_load_en       = ($urandom_range(0, 15) == 0);
                i_load_addr     = 7'($urandom_range(0, 127));
                i_load_data     = $urandom;
                i_start         = ($urandom_range(0, 15) == 0);
                tick("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the pipelined MIPS core: owns the program counter and the instruction memory, and drives the instruction word and PC+4 into the IF/ID pipeline register. It consumes the stall (PC write enable) and redirect requests from the ID-stage hazard and branch logic. It also implements the debug-facing program load, start, step and halt control.

## Interface
- NB_INSTRUCT, 32, instruction word width
- NB_PC, 9, PC width in bytes; memory depth = 2^(NB_PC-2) words
- HALT_WORD, 32'hFFFF_FFFF, encoding that stops fetch
- i_clk  in  1  clock; all state updates on its rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_load_en  in  1  write i_load_data into instruction memory (IDLE only)
- i_load_addr  in  NB_PC-2  word address for load
- i_load_data  in  NB_INSTRUCT  word to load
- i_start  in  1  one-cycle pulse, IDLE -> RUN
- i_step_mode  in  1  1 = advance only on i_step
- i_step  in  1  one-cycle pulse, permits one advance in step mode
- i_PC_write  in  1  from hazard unit; 0 = stall (hold PC and instruction)
- i_branch_taken  in  1  redirect to i_branch_target
- i_branch_target  in  NB_PC  byte address
- i_jump  in  1  redirect to i_jump_target
- i_jump_target  in  NB_PC  byte address
- o_instruction  out  NB_INSTRUCT  fetched word (to IF/ID)
- o_PC  out  NB_PC  PC+4 of the word on o_instruction (to IF/ID)
- o_valid  out  1  o_instruction is a real fetched word
- o_halted  out  1  HALT state reached

## Operation
- States: IDLE, RUN, HALT. Reset -> IDLE.
- IDLE: i_load_en=1 writes mem[i_load_addr] <= i_load_data. i_start=1 with i_load_en=0 -> RUN, pc <= 0, instr <= mem[0]. i_start is ignored while i_load_en=1.
- RUN: advance = i_PC_write & (~i_step_mode | i_step) & (instr != HALT_WORD).
- pc_next priority: i_branch_taken -> i_branch_target; else i_jump -> i_jump_target; else pc+4.
- On advance: pc <= pc_next, instr <= mem[pc_next[NB_PC-1:2]]. Target bits [1:0] are ignored (word-aligned).
- Redirects are gated by advance. The hazard unit holds a redirect asserted through a stall.
- Not advancing: pc and instr hold.
- pc+4 wraps modulo 2^NB_PC: 0x1FC -> 0x000.
- instr == HALT_WORD in RUN -> HALT next edge. The PC is frozen from the cycle the word appears.
- HALT: o_instruction stays HALT_WORD and o_halted=1. Loads, start, step and redirects are ignored. Exit only via reset.
- i_load_en outside IDLE is ignored; memory is unchanged.
- Outputs: o_instruction = instr; o_PC = pc+4 (same wrap); o_valid = (state != IDLE).
- Memory contents are not cleared by reset.

## Timing
- Reset values: o_instruction=0, o_PC=0, o_valid=0, o_halted=0, pc=0, state=IDLE. Reset is effective immediately (asynchronous), including mid-RUN.
- Reset release is synchronous to i_clk.
- Load: mem written at the edge where i_load_en=1. A load at edge N is readable by a start at edge N+1.
- Start at edge N: o_instruction=mem[0], o_PC=4, o_valid=1 after edge N.
- Fetch latency: one edge. The word at pc_next appears on o_instruction together with the new o_PC.
- Stall: i_PC_write=0 on edge N means o_instruction/o_PC after N equal their values before N.
- Step mode: exactly one advance per i_step pulse. i_step while i_PC_write=0 is lost and not queued.
- o_halted rises one edge after HALT_WORD first appears on o_instruction.

## Test plan
- Load mem[0..3] = 0x20010005, 0x20020003, 0x00221820, 0xFFFFFFFF; pulse start; free-run -> o_PC sequence 4, 8, 12, 16. o_halted=1 one cycle after 0xFFFFFFFF appears; the outputs then hold indefinitely.
- RUN with i_PC_write=0 for 3 cycles at pc=8 -> o_instruction=mem[2] and o_PC=12 held for 3 cycles, then resume at mem[3].
- At pc=4, assert i_branch_taken=1 (target 0x40) and i_jump=1 (target 0x80) together -> next o_PC=0x44, o_instruction=mem[16].
- Step mode, step pulses 2 cycles apart -> the PC advances exactly once per pulse. A step during i_PC_write=0 leaves the PC unchanged.
- Jump to 0x1FC with sequential fetch -> o_PC=0x000, then next fetch is mem[0] (wrap).
- Assert reset mid-RUN at pc=0x20 -> all outputs 0 immediately, state IDLE. A load and start after release works, and the previously loaded memory is intact.
